// File: rtl/axis_split_pkg.sv
// Shared definitions for the lockstep AXI-Stream packet splitter family:
// controller state encoding and sideband field width helper.
package axis_split_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } split_state_t;

    localparam int SIDEBAND_WIDTH = 8;

    // Disabled sideband fields keep a minimum width of one bit so port widths never collapse to zero.
    function automatic int field_width(input bit enable, input int enabled_width);
        return enable ? enabled_width : 1;
    endfunction

endpackage

// File: rtl/axis_lockstep_join.sv
// Lockstep handshake join: all enabled lanes must be valid (and ready) before
// any lane may move a beat.
module axis_lockstep_join #(
    parameter int CHANNELS = 4
) (
    input  logic [CHANNELS-1:0] valid,
    input  logic [CHANNELS-1:0] ready,
    input  logic [CHANNELS-1:0] mask,
    input  logic                enable,
    output logic                all_v,
    output logic                fire
);

    logic all_r;

    // Masked-off lanes count as satisfied so they never stall the group.
    assign all_v = &(valid | ~mask);
    assign all_r = &(ready | ~mask);
    assign fire  = enable & all_v & all_r;

endmodule

// File: rtl/axis_packet_splitter_mc.sv
// Multi-channel lockstep packet splitter: re-frames enabled lanes into packets of
// a run-time size, regenerating tlast, for a bounded or tlast-terminated run.
module axis_packet_splitter_mc
    import axis_split_pkg::*;
#(
    parameter int CHANNELS            = 4,
    parameter int DATA_WIDTH          = 16,
    parameter bit KEEP_ENABLE         = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH          = KEEP_ENABLE ? (DATA_WIDTH + 7) / 8 : 1,
    parameter bit ID_ENABLE           = 1'b0,
    parameter bit DEST_ENABLE         = 1'b0,
    parameter bit USER_ENABLE         = 1'b0,
    parameter int ID_WIDTH            = field_width(ID_ENABLE, SIDEBAND_WIDTH),
    parameter int DEST_WIDTH          = field_width(DEST_ENABLE, SIDEBAND_WIDTH),
    parameter int USER_WIDTH          = field_width(USER_ENABLE, SIDEBAND_WIDTH),
    parameter int PCKT_WIDTH          = 32,
    parameter int CNT_WIDTH           = 16,
    parameter bit ALLOW_LOCKS         = 1'b1,
    parameter bit RAISE_NON_DIVISIBLE = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             operation_start,
    input  logic [PCKT_WIDTH-1:0]            pckt_size,
    input  logic [CNT_WIDTH-1:0]             pckt_count,
    input  logic [CHANNELS-1:0]              chan_mask,
    input  logic                             lock,
    input  logic                             external_error,
    output logic                             operation_busy,
    output logic                             operation_complete,
    output logic                             operation_error,
    output logic [PCKT_WIDTH-1:0]            beats_done,
    output logic [CNT_WIDTH-1:0]             pckts_done,
    input  logic [CHANNELS*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [CHANNELS*KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic [CHANNELS-1:0]              s_axis_tvalid,
    output logic [CHANNELS-1:0]              s_axis_tready,
    input  logic [CHANNELS-1:0]              s_axis_tlast,
    input  logic [CHANNELS*ID_WIDTH-1:0]     s_axis_tid,
    input  logic [CHANNELS*DEST_WIDTH-1:0]   s_axis_tdest,
    input  logic [CHANNELS*USER_WIDTH-1:0]   s_axis_tuser,
    output logic [CHANNELS*DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [CHANNELS*KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic [CHANNELS-1:0]              m_axis_tvalid,
    input  logic [CHANNELS-1:0]              m_axis_tready,
    output logic [CHANNELS-1:0]              m_axis_tlast,
    output logic [CHANNELS*ID_WIDTH-1:0]     m_axis_tid,
    output logic [CHANNELS*DEST_WIDTH-1:0]   m_axis_tdest,
    output logic [CHANNELS*USER_WIDTH-1:0]   m_axis_tuser
);

    split_state_t          state;
    logic [PCKT_WIDTH-1:0] size_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CHANNELS-1:0]   mask_q;
    logic [PCKT_WIDTH-1:0] beat_cnt;
    logic [CNT_WIDTH-1:0]  pkt_cnt;
    logic                  busy_q;
    logic                  complete_q;
    logic                  error_q;

    logic                  lk;
    logic                  run_ok;
    logic                  all_v;
    logic                  fire;
    logic                  last_beat;
    logic [CNT_WIDTH-1:0]  pkt_next;
    logic [CHANNELS-1:0]   en_tlast;
    logic                  any_tlast;
    logic                  tlast_split;
    logic                  first_tlast;
    logic                  bounded;
    logic                  err_beat;
    logic                  done_beat;
    logic                  bad_start;

    assign lk     = lock & ALLOW_LOCKS;
    assign run_ok = (state == ST_RUN) & ~lk;

    axis_lockstep_join #(
        .CHANNELS(CHANNELS)
    ) u_join (
        .valid (s_axis_tvalid),
        .ready (m_axis_tready),
        .mask  (mask_q),
        .enable(run_ok),
        .all_v (all_v),
        .fire  (fire)
    );

    assign last_beat   = (beat_cnt == size_q - PCKT_WIDTH'(1));
    assign pkt_next    = pkt_cnt + CNT_WIDTH'(1);
    assign en_tlast    = s_axis_tlast & mask_q;
    assign any_tlast   = |en_tlast;
    assign tlast_split = any_tlast && (en_tlast != mask_q);
    assign bounded     = (count_q != '0);
    assign bad_start   = (pckt_size == '0) || (chan_mask == '0);

    // The lowest enabled lane is the reference lane for unbounded termination.
    always_comb begin
        first_tlast = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_tlast = s_axis_tlast[i];
            end
        end
    end

    assign err_beat  = RAISE_NON_DIVISIBLE &&
                       ((any_tlast && !last_beat) || tlast_split ||
                        (bounded && any_tlast && last_beat && (pkt_next != count_q)));
    assign done_beat = bounded ? (last_beat && (pkt_next == count_q))
                               : (first_tlast && last_beat);

    assign m_axis_tvalid = (run_ok && all_v) ? mask_q : '0;
    assign s_axis_tready = fire ? mask_q : '0;
    assign m_axis_tlast  = last_beat ? mask_q : '0;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        assign m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] =
            mask_q[i] ? s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign m_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] =
            (KEEP_ENABLE && mask_q[i]) ? s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] : '0;
        assign m_axis_tid[i*ID_WIDTH +: ID_WIDTH] =
            (ID_ENABLE && mask_q[i]) ? s_axis_tid[i*ID_WIDTH +: ID_WIDTH] : '0;
        assign m_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH] =
            (DEST_ENABLE && mask_q[i]) ? s_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH] : '0;
        assign m_axis_tuser[i*USER_WIDTH +: USER_WIDTH] =
            (USER_ENABLE && mask_q[i]) ? s_axis_tuser[i*USER_WIDTH +: USER_WIDTH] : '0;
    end

    // Lock freezes everything, including state; a beat that errors is still counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            size_q     <= '0;
            count_q    <= '0;
            mask_q     <= '0;
            beat_cnt   <= '0;
            pkt_cnt    <= '0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            error_q    <= 1'b0;
        end else if (!lk) begin
            if (fire) begin
                if (last_beat) begin
                    beat_cnt <= '0;
                    pkt_cnt  <= pkt_next;
                end else begin
                    beat_cnt <= beat_cnt + PCKT_WIDTH'(1);
                end
            end
            case (state)
                ST_RUN: begin
                    if (external_error || (fire && err_beat)) begin
                        state   <= ST_ERROR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else if (fire && done_beat) begin
                        state      <= ST_DONE;
                        busy_q     <= 1'b0;
                        complete_q <= 1'b1;
                    end
                end
                default: begin
                    if (external_error && (state != ST_IDLE)) begin
                        state      <= ST_ERROR;
                        complete_q <= 1'b0;
                        error_q    <= 1'b1;
                    end else if (operation_start) begin
                        size_q     <= pckt_size;
                        count_q    <= pckt_count;
                        mask_q     <= chan_mask;
                        beat_cnt   <= '0;
                        pkt_cnt    <= '0;
                        complete_q <= 1'b0;
                        if (bad_start) begin
                            state   <= ST_ERROR;
                            error_q <= 1'b1;
                        end else begin
                            state   <= ST_RUN;
                            busy_q  <= 1'b1;
                            error_q <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign operation_busy     = busy_q;
    assign operation_complete = complete_q;
    assign operation_error    = error_q;
    assign beats_done         = beat_cnt;
    assign pckts_done         = pkt_cnt;

endmodule

// File: tb/tb_axis_packet_splitter_mc.sv
// Self-checking bench for axis_packet_splitter_mc: directed scenarios plus a
// randomized run, all checked against a beat-counting reference model.
module tb_axis_packet_splitter_mc;

    localparam int CH = 4;
    localparam int DW = 16;
    localparam int KW = 2;
    localparam int PW = 32;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           operation_start = 1'b0;
    logic [PW-1:0]  pckt_size = '0;
    logic [CW-1:0]  pckt_count = '0;
    logic [CH-1:0]  chan_mask = '0;
    logic           lock = 1'b0;
    logic           external_error = 1'b0;
    logic [CH*DW-1:0] s_axis_tdata = '0;
    logic [CH*KW-1:0] s_axis_tkeep = '0;
    logic [CH-1:0]  s_axis_tvalid = '0;
    logic [CH-1:0]  s_axis_tlast = '0;
    logic [CH-1:0]  s_axis_tid = '0;
    logic [CH-1:0]  s_axis_tdest = '0;
    logic [CH-1:0]  s_axis_tuser = '0;
    logic [CH-1:0]  m_axis_tready = '0;

    logic           operation_busy, operation_complete, operation_error;
    logic [PW-1:0]  beats_done;
    logic [CW-1:0]  pckts_done;
    logic [CH-1:0]  s_axis_tready, m_axis_tvalid, m_axis_tlast;
    logic [CH*DW-1:0] m_axis_tdata;
    logic [CH*KW-1:0] m_axis_tkeep;
    logic [CH-1:0]  m_axis_tid, m_axis_tdest, m_axis_tuser;

    logic           nl_busy, nl_complete, nl_error;
    logic [PW-1:0]  nl_beats;
    logic [CW-1:0]  nl_pckts;
    logic [CH-1:0]  nl_tready, nl_tvalid, nl_tlast;
    logic [CH*DW-1:0] nl_tdata;
    logic [CH*KW-1:0] nl_tkeep;
    logic [CH-1:0]  nl_tid, nl_tdest, nl_tuser;

    axis_packet_splitter_mc dut (
        .clk(clk), .rst(rst), .operation_start(operation_start),
        .pckt_size(pckt_size), .pckt_count(pckt_count), .chan_mask(chan_mask),
        .lock(lock), .external_error(external_error),
        .operation_busy(operation_busy), .operation_complete(operation_complete),
        .operation_error(operation_error), .beats_done(beats_done), .pckts_done(pckts_done),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
        .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
        .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser)
    );

    // Second instance with locks disabled shares every input with the first.
    axis_packet_splitter_mc #(.ALLOW_LOCKS(1'b0)) dut_nolock (
        .clk(clk), .rst(rst), .operation_start(operation_start),
        .pckt_size(pckt_size), .pckt_count(pckt_count), .chan_mask(chan_mask),
        .lock(lock), .external_error(external_error),
        .operation_busy(nl_busy), .operation_complete(nl_complete),
        .operation_error(nl_error), .beats_done(nl_beats), .pckts_done(nl_pckts),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(nl_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
        .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(nl_tdata), .m_axis_tkeep(nl_tkeep), .m_axis_tvalid(nl_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(nl_tlast), .m_axis_tid(nl_tid),
        .m_axis_tdest(nl_tdest), .m_axis_tuser(nl_tuser)
    );

    int n_compared = 0;
    int n_mismatched = 0;

    // Reference model: operation flags plus total beats moved in this operation.
    bit          md_idle, md_run, md_cmpl, md_err;
    int          md_size, md_count, md_beats;
    logic [CH-1:0] md_mask;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        md_idle = 1'b1; md_run = 1'b0; md_cmpl = 1'b0; md_err = 1'b0;
        md_size = 0; md_count = 0; md_beats = 0; md_mask = '0;
    endtask

    function automatic bit model_fire();
        return md_run && !lock && (&(s_axis_tvalid | ~md_mask)) && (&(m_axis_tready | ~md_mask));
    endfunction

    function automatic bit model_tlast_beat();
        return (md_size != 0) && ((md_beats % md_size) == md_size - 1);
    endfunction

    task automatic model_step();
        logic [CH-1:0] en_tl;
        bit fire, tl_out, first, err, done;
        int pk;
        if (rst) begin
            model_reset();
            return;
        end
        if (lock) return;
        if (md_run) begin
            fire = model_fire();
            err = 1'b0; done = 1'b0; first = 1'b0;
            if (fire) begin
                tl_out = model_tlast_beat();
                en_tl = s_axis_tlast & md_mask;
                for (int i = 0; i < CH; i++) begin
                    if (md_mask[i]) begin
                        first = s_axis_tlast[i];
                        break;
                    end
                end
                md_beats++;
                pk = md_beats / md_size;
                err = (en_tl != 0 && !tl_out) || (en_tl != 0 && en_tl != md_mask) ||
                      (md_count != 0 && en_tl != 0 && tl_out && pk < md_count);
                done = (md_count != 0) ? (tl_out && pk == md_count) : (first && tl_out);
            end
            if (external_error || err) begin
                md_run = 1'b0; md_err = 1'b1;
            end else if (done) begin
                md_run = 1'b0; md_cmpl = 1'b1;
            end
        end else if (external_error && !md_idle) begin
            md_cmpl = 1'b0; md_err = 1'b1;
        end else if (operation_start) begin
            md_idle = 1'b0; md_cmpl = 1'b0; md_err = 1'b0;
            md_size = int'(pckt_size); md_count = int'(pckt_count); md_mask = chan_mask;
            md_beats = 0;
            if (md_size == 0 || md_mask == 0) md_err = 1'b1;
            else md_run = 1'b1;
        end
    endtask

    task automatic compare_outputs();
        logic [CH*DW-1:0] exp_data;
        logic [CH*KW-1:0] exp_keep;
        bit run_v;
        run_v = md_run && !lock && (&(s_axis_tvalid | ~md_mask));
        for (int i = 0; i < CH; i++) begin
            exp_data[i*DW +: DW] = md_mask[i] ? s_axis_tdata[i*DW +: DW] : '0;
            exp_keep[i*KW +: KW] = md_mask[i] ? s_axis_tkeep[i*KW +: KW] : '0;
        end
        checkOutput("busy", 64'(operation_busy), 64'(md_run));
        checkOutput("complete", 64'(operation_complete), 64'(md_cmpl));
        checkOutput("error", 64'(operation_error), 64'(md_err));
        checkOutput("beats_done", 64'(beats_done), 64'(md_size != 0 ? md_beats % md_size : 0));
        checkOutput("pckts_done", 64'(pckts_done), 64'(md_size != 0 ? md_beats / md_size : 0));
        checkOutput("m_tvalid", 64'(m_axis_tvalid), 64'(run_v ? md_mask : '0));
        checkOutput("s_tready", 64'(s_axis_tready), 64'(model_fire() ? md_mask : '0));
        checkOutput("m_tlast", 64'(m_axis_tlast), 64'(model_tlast_beat() ? md_mask : '0));
        checkOutput("m_tdata", 64'(m_axis_tdata), 64'(exp_data));
        checkOutput("m_tkeep", 64'(m_axis_tkeep), 64'(exp_keep));
        checkOutput("m_side", 64'({m_axis_tid, m_axis_tdest, m_axis_tuser}), 64'(0));
    endtask

    // One clock of stimulus: entered and left at posedge+1 with control inputs set by the caller.
    task automatic applyStimulus();
        s_axis_tdata = {$urandom, $urandom};
        s_axis_tkeep = 8'($urandom);
        s_axis_tid   = 4'($urandom);
        s_axis_tdest = 4'($urandom);
        s_axis_tuser = 4'($urandom);
        #2;
        compare_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; operation_start = 1'b0; lock = 1'b0; external_error = 1'b0;
        s_axis_tvalid = '0; m_axis_tready = '0; s_axis_tlast = '0;
    endtask

    task automatic start_op(input int size, input int cnt, input logic [CH-1:0] mask);
        operation_start = 1'b1;
        pckt_size = PW'(size);
        pckt_count = CW'(cnt);
        chan_mask = mask;
        applyStimulus();
        operation_start = 1'b0;
    endtask

    task automatic run_beats(input int n);
        s_axis_tvalid = '1; m_axis_tready = '1;
        for (int b = 0; b < n; b++) applyStimulus();
    endtask

    int plan_k;

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        idle_inputs();

        // Reset state
        applyStimulus();
        checkOutput("rst_busy", 64'(operation_busy), 64'(0));
        checkOutput("rst_beats", 64'(beats_done), 64'(0));
        checkOutput("rst_pckts", 64'(pckts_done), 64'(0));
        checkOutput("rst_tvalid", 64'(m_axis_tvalid), 64'(0));

        // Bounded run: size 4, count 3, all lanes
        start_op(4, 3, 4'hF);
        s_axis_tvalid = '1; m_axis_tready = '1;
        for (int b = 1; b <= 12; b++) begin
            checkOutput("t1_tlast", 64'(m_axis_tlast), 64'((b % 4 == 0) ? 4'hF : 4'h0));
            applyStimulus();
        end
        checkOutput("t1_complete", 64'(operation_complete), 64'(1));
        checkOutput("t1_pckts", 64'(pckts_done), 64'(3));
        checkOutput("t1_busy", 64'(operation_busy), 64'(0));

        // Masked lanes: disabled lanes 1 and 3 stall nothing and stay quiet
        idle_inputs();
        start_op(2, 2, 4'b0101);
        s_axis_tvalid = 4'b0111; m_axis_tready = 4'b1101;
        for (int b = 0; b < 4; b++) begin
            #1;
            checkOutput("t3_sready_off", 64'(s_axis_tready & 4'b1010), 64'(0));
            checkOutput("t3_mvalid_off", 64'(m_axis_tvalid & 4'b1010), 64'(0));
            applyStimulus();
        end
        checkOutput("t3_complete", 64'(operation_complete), 64'(1));
        checkOutput("t3_pckts", 64'(pckts_done), 64'(2));

        // Unbounded: tlast on beat 10 completes, tlast on beat 7 errors
        idle_inputs();
        start_op(5, 0, 4'hF);
        s_axis_tvalid = '1; m_axis_tready = '1;
        for (int b = 1; b <= 10; b++) begin
            s_axis_tlast = (b == 10) ? 4'hF : 4'h0;
            applyStimulus();
        end
        checkOutput("t4_complete", 64'(operation_complete), 64'(1));
        checkOutput("t4_pckts", 64'(pckts_done), 64'(2));
        idle_inputs();
        start_op(5, 0, 4'hF);
        s_axis_tvalid = '1; m_axis_tready = '1;
        for (int b = 1; b <= 7; b++) begin
            s_axis_tlast = (b == 7) ? 4'hF : 4'h0;
            applyStimulus();
        end
        checkOutput("t4_error", 64'(operation_error), 64'(1));
        checkOutput("t4_beats", 64'(beats_done), 64'(2));
        checkOutput("t4_epckts", 64'(pckts_done), 64'(1));

        // Lock: frozen on the locking instance, ignored on the other
        idle_inputs();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        start_op(4, 2, 4'hF);
        run_beats(2);
        lock = 1'b1;
        for (int c = 0; c < 3; c++) applyStimulus();
        lock = 1'b0;
        checkOutput("t5_beats_locked", 64'(beats_done), 64'(2));
        checkOutput("t5_nl_beats", 64'(nl_beats), 64'(1));
        checkOutput("t5_nl_pckts", 64'(nl_pckts), 64'(1));
        run_beats(6);
        checkOutput("t5_complete", 64'(operation_complete), 64'(1));
        checkOutput("t5_pckts", 64'(pckts_done), 64'(2));
        checkOutput("t5_nl_complete", 64'(nl_complete), 64'(1));

        // Zero size start errors without busy, a good start recovers
        idle_inputs();
        start_op(0, 2, 4'hF);
        checkOutput("t6_error", 64'(operation_error), 64'(1));
        checkOutput("t6_busy", 64'(operation_busy), 64'(0));
        applyStimulus();
        checkOutput("t6_busy_hold", 64'(operation_busy), 64'(0));
        start_op(3, 1, 4'hF);
        checkOutput("t6_busy_run", 64'(operation_busy), 64'(1));
        checkOutput("t6_error_clr", 64'(operation_error), 64'(0));
        run_beats(3);

        // Reset mid-packet aborts, next operation starts from beat 0
        idle_inputs();
        start_op(4, 1, 4'hF);
        run_beats(2);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkOutput("t7_busy", 64'(operation_busy), 64'(0));
        checkOutput("t7_beats", 64'(beats_done), 64'(0));
        checkOutput("t7_tvalid", 64'(m_axis_tvalid), 64'(0));
        checkOutput("t7_tlast", 64'(m_axis_tlast), 64'(0));
        idle_inputs();
        start_op(4, 1, 4'hF);
        run_beats(4);
        checkOutput("t7_complete", 64'(operation_complete), 64'(1));
        checkOutput("t7_pckts", 64'(pckts_done), 64'(1));

        // Randomized traffic against the model
        idle_inputs();
        plan_k = 1;
        for (int c = 0; c < 3000; c++) begin
            operation_start = ($urandom_range(0, 99) < (md_run ? 2 : 20));
            pckt_size = PW'(($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 5));
            pckt_count = CW'($urandom_range(0, 3));
            chan_mask = CH'($urandom_range(0, 15));
            if (operation_start) begin
                if (pckt_count == 0)
                    plan_k = ($urandom_range(0, 1) == 1) ? int'(pckt_size) * $urandom_range(1, 3)
                                                         : $urandom_range(1, 3 * int'(pckt_size) + 1);
                else
                    plan_k = ($urandom_range(0, 1) == 1) ? int'(pckt_size) * int'(pckt_count)
                                                         : $urandom_range(1, int'(pckt_size) * int'(pckt_count) + 1);
            end
            for (int i = 0; i < CH; i++) begin
                s_axis_tvalid[i] = ($urandom_range(0, 99) < 85);
                m_axis_tready[i] = ($urandom_range(0, 99) < 85);
                s_axis_tlast[i]  = md_mask[i] ? (md_beats + 1 == plan_k) : 1'($urandom);
            end
            if ($urandom_range(0, 99) < 3) s_axis_tlast[$urandom_range(0, CH - 1)] ^= 1'b1;
            lock = ($urandom_range(0, 99) < 5);
            external_error = ($urandom_range(0, 99) < 1);
            rst = ($urandom_range(0, 999) < 3);
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
